// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS two-master bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    MID_I = 1'b0,
    MID_D = 1'b1
  } master_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mips_bus_watchdog.sv
// Slave-stall watchdog: counts stalled BUSY cycles and flags the one that hits the limit.
module mips_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Fires during the stalled cycle that would make the count reach the limit.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   count <= '0;
    else if (clear)               count <= '0;
    else if (enable && !expired)  count <= count + 1'b1;
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates instruction-fetch and data masters onto one Avalon-style memory bus.
// Define MIPS_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: data master wins).
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_error
);

  arb_state_e  state;
  master_e     gnt, pick;
  logic        i_req, d_req, any_req, busy, stall, done, expired, grant;
  logic [31:0] rdata_ret;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  master_e last_gnt;
`endif

  assign i_req     = i_read;
  assign d_req     = d_read | d_write;
  assign any_req   = i_req | d_req;
  assign busy      = (state != IDLE);
  assign gnt       = (state == BUSY_D) ? MID_D : MID_I;
  assign grant     = (state == IDLE) && any_req;
  assign stall     = busy & waitrequest;
  assign done      = busy & (~waitrequest | expired);
  assign rdata_ret = expired ? BUS_ERR_DATA : readdata;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  assign pick = (d_req && (!i_req || last_gnt == MID_I)) ? MID_D : MID_I;
`else
  assign pick = d_req ? MID_D : MID_I;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      last_gnt   <= MID_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (pick == MID_D) begin
              state      <= BUSY_D;
              address    <= d_address;
              writedata  <= d_writedata;
              byteenable <= d_byteenable;
              // A simultaneous read+write request is treated as a write.
              write      <= d_write;
              read       <= d_read & ~d_write;
            end else begin
              state      <= BUSY_I;
              address    <= i_address;
              writedata  <= '0;
              byteenable <= 4'b1111;
              write      <= 1'b0;
              read       <= 1'b1;
            end
`ifdef MIPS_ARB_ROUND_ROBIN_EN
            last_gnt <= pick;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state <= IDLE;
            read  <= 1'b0;
            write <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          read  <= 1'b0;
          write <= 1'b0;
        end
      endcase
    end
  end

  mips_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant),
    .enable  (stall),
    .expired (expired)
  );

  // Response path is combinational so the master sees completion in the same cycle as the slave.
  always_comb begin
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    if (busy && gnt == MID_I) begin
      i_waitrequest = ~done;
      if (done) i_readdata = rdata_ret;
    end
    if (busy && gnt == MID_D) begin
      d_waitrequest = ~done;
      if (done) d_readdata = rdata_ret;
    end
  end

  assign bus_error = expired;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: masters queue expected transfers, a negedge monitor checks them.
module tb_mips_bus_arbiter;

  localparam int TO = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address, d_address, d_writedata, address, writedata, readdata;
  logic [31:0] i_readdata, d_readdata;
  logic        i_read, i_waitrequest, d_read, d_write, d_waitrequest;
  logic [3:0]  d_byteenable, byteenable;
  logic        read, write, bus_error;
  logic        waitrequest = 1'b1;
  int          wr_mode = 0;
  int          stuck = 0;

  int vectors = 0;
  int miscompares = 0;

  txn_t i_q[$];
  txn_t d_q[$];
  txn_t cur_t, bus_now;
  logic have_cur = 1'b0, cur_d = 1'b0, last_d = 1'b0;
  logic prev_act = 1'b0, prev_i = 1'b0, prev_d = 1'b0;
  int   stalls = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .bus_error(bus_error)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h8C030001;
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  assign readdata = mem_fn(address);
  assign bus_now  = {address, writedata, byteenable, read, write};

  // Slave: 0 = always ready, 1 = stall forever, 2 = random with occasional long stalls.
  always @(posedge clk) begin
    #1;
    case (wr_mode)
      0: waitrequest = 1'b0;
      1: waitrequest = 1'b1;
      default: begin
        if (stuck == 0 && $urandom_range(0, 39) == 0) stuck = 11;
        if (stuck > 0) begin
          waitrequest = 1'b1;
          stuck--;
        end else begin
          waitrequest = ($urandom_range(0, 99) < 40);
        end
      end
    endcase
  end

  task automatic chk1(input string nm, input logic a, input logic e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chkt(input string nm, input txn_t a, input txn_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got addr=%h wd=%h be=%h rd=%b wr=%b expected addr=%h wd=%h be=%h rd=%b wr=%b (t=%0t)",
               nm, a.addr, a.wdata, a.be, a.rd, a.wr, e.addr, e.wdata, e.be, e.rd, e.wr, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected condition expected none (t=%0t)", nm, $time);
  endtask

  // Returns at posedge+1 after the cycle in which the master saw waitrequest low.
  task automatic wait_done(input logic is_d);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((is_d ? d_waitrequest : i_waitrequest) == 1'b0) break;
      if (++n > 300) begin
        fail_now(is_d ? "d_done_timeout" : "i_done_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic i_issue(input logic [31:0] a);
    i_address = a;
    i_read    = 1'b1;
    i_q.push_back('{addr: a, wdata: 32'h0, be: 4'hF, rd: 1'b1, wr: 1'b0});
    wait_done(1'b0);
    i_read = 1'b0;
  endtask

  task automatic d_issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic rd, input logic wr);
    d_address    = a;
    d_writedata  = wd;
    d_byteenable = be;
    d_read       = rd;
    d_write      = wr;
    d_q.push_back('{addr: a, wdata: wd, be: be, rd: rd & ~wr, wr: wr});
    wait_done(1'b1);
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  // Monitor: every granted transfer must match the head of the winner's queue.
  always @(negedge clk) begin
    logic act, abort, exp_wr, g_wr, o_wr;
    logic [31:0] g_rd, o_rd;
    act = read | write;
    if (!reset) begin
      chkt("rst_bus", bus_now, '0);
      chk1("rst_i_wait", i_waitrequest, 1'b1);
      chk1("rst_d_wait", d_waitrequest, 1'b1);
      chk1("rst_bus_error", bus_error, 1'b0);
      i_q.delete();
      d_q.delete();
      have_cur = 1'b0;
      last_d   = 1'b0;
      prev_act = 1'b0;
      prev_i   = 1'b0;
      prev_d   = 1'b0;
    end else begin
      if (!have_cur && !prev_act && (prev_i || prev_d)) chk1("grant_taken", act, 1'b1);
      if (!have_cur && act) begin
        if (prev_act) fail_now("no_idle_gap");
        if (!(prev_i || prev_d)) fail_now("spurious_grant");
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        cur_d = prev_d && (!prev_i || !last_d);
`else
        cur_d = prev_d;
`endif
        last_d = cur_d;
        if ((cur_d && d_q.size() == 0) || (!cur_d && i_q.size() == 0)) begin
          fail_now("no_pending_txn");
        end else begin
          cur_t    = cur_d ? d_q[0] : i_q[0];
          have_cur = 1'b1;
          stalls   = 0;
        end
      end
      if (have_cur) begin
        chkt(cur_d ? "d_bus_fields" : "i_bus_fields", bus_now, cur_t);
        abort  = waitrequest && (stalls + 1 == TO);
        exp_wr = waitrequest && !abort;
        g_wr   = cur_d ? d_waitrequest : i_waitrequest;
        o_wr   = cur_d ? i_waitrequest : d_waitrequest;
        g_rd   = cur_d ? d_readdata : i_readdata;
        o_rd   = cur_d ? i_readdata : d_readdata;
        chk1("gnt_wait", g_wr, exp_wr);
        chk1("other_wait", o_wr, 1'b1);
        chk32("other_rdata", o_rd, 32'h0);
        chk1("bus_error", bus_error, abort);
        if (!exp_wr) begin
          chk32(abort ? "abort_rdata" : "rdata", g_rd, abort ? 32'hDEADBEEF : mem_fn(cur_t.addr));
          if (cur_d) void'(d_q.pop_front());
          else       void'(i_q.pop_front());
          have_cur = 1'b0;
        end else begin
          chk32("stall_rdata", g_rd, 32'h0);
          stalls++;
        end
      end else if (!act) begin
        chk1("idle_i_wait", i_waitrequest, 1'b1);
        chk1("idle_d_wait", d_waitrequest, 1'b1);
        chk32("idle_i_rdata", i_readdata, 32'h0);
        chk32("idle_d_rdata", d_readdata, 32'h0);
        chk1("idle_bus_error", bus_error, 1'b0);
      end
      prev_act = act;
      prev_i   = i_read;
      prev_d   = d_read | d_write;
    end
  end

  initial begin
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_byteenable = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Boot fetch with a ready slave.
    i_issue(32'hBFC00000);

    // Simultaneous fetch and data write.
    fork
      i_issue(32'h0000_0040);
      d_issue(32'h0000_0001, 32'd192, 4'b0011, 1'b0, 1'b1);
    join

    // Read and write together on the data master.
    d_issue(32'h0000_2000, 32'hCAFE0001, 4'hF, 1'b1, 1'b1);

    // Stuck slave -> watchdog abort.
    wr_mode = 1;
    d_issue(32'h0000_3000, 32'h0, 4'hF, 1'b1, 1'b0);
    wr_mode = 0;

    // Both masters requesting back to back.
    fork
      for (int k = 0; k < 4; k++) i_issue(32'h0000_0400 + 32'(k * 4));
      for (int k = 0; k < 4; k++) d_issue(32'h0000_0800 + 32'(k * 4), 32'h0, 4'hF, 1'b1, 1'b0);
    join

    // Randomized traffic against a stalling slave.
    wr_mode = 2;
    fork
      for (int k = 0; k < 50; k++) begin
        int n;
        n = $urandom_range(0, 3);
        if (n != 0) begin
          repeat (n) @(posedge clk);
          #1;
        end
        i_issue($urandom & 32'hFFFF_FFFC);
      end
      for (int k = 0; k < 50; k++) begin
        int n, op;
        n  = $urandom_range(0, 3);
        op = $urandom_range(0, 2);
        if (n != 0) begin
          repeat (n) @(posedge clk);
          #1;
        end
        d_issue($urandom, $urandom, 4'($urandom_range(1, 15)), op != 1, op != 0);
      end
    join
    wr_mode = 0;
    @(posedge clk); #1;

    // Reset in the middle of a stalled data write.
    wr_mode = 1;
    d_address = 32'h0000_5000; d_writedata = 32'h1234_5678; d_byteenable = 4'hF;
    d_read = 1'b0; d_write = 1'b1;
    d_q.push_back('{addr: 32'h0000_5000, wdata: 32'h1234_5678, be: 4'hF, rd: 1'b0, wr: 1'b1});
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk1("rst_busy_write", write, 1'b0);
    chk1("rst_busy_d_wait", d_waitrequest, 1'b1);
    chk32("rst_busy_addr", address, 32'h0);
    d_write = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    wr_mode = 0;
    @(posedge clk); #1;
    i_issue(32'h0000_6000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
